// File: rtl/ctr593_seq.sv
// ============================================================================
// ctr593_seq : SN74LS593 counter sequencer (load, count, readback, tc pulse)
// Optional macro CTR593_RELOAD_EN: terminal count reloads the preset and keeps running.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctr593_seq #(
  parameter int unsigned RD_WAIT = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       start,
  input  logic       stop,
  input  logic       rd,
  input  logic       tick,
  input  logic       rco,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       cck,
  output logic       rck,
  output logic       ccken,
  output logic       cclr,
  output logic       cload,
  output logic       g,
  output logic       g_,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       tc,
  output logic       busy,
  output logic       running
);

  localparam logic [15:0] c_wait = (RD_WAIT == 0) ? 16'd1 : RD_WAIT[15:0];

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_DRV  = 3'd1,
    S_LD_RCK  = 3'd2,
    S_LD_CLD  = 3'd3,
    S_RUN     = 3'd4,
    S_RD_EN   = 3'd5,
    S_RD_TURN = 3'd6
  } state_t;

  state_t      r_state, w_state, r_ret, w_ret;
  logic [15:0] r_wcnt, w_wcnt;
  logic [7:0]  r_preset, r_io_out, w_io_out, r_rdata, w_rdata;
  logic        r_rco, r_rco_q, w_fall, w_tick_ok, w_rd_st, w_counting;
  logic        r_oe, r_cck, r_rck, r_ccken, r_cclr, r_cload, r_g, r_gn;
  logic        r_rvalid, r_tc, r_busy, r_running;

  assign w_fall = r_rco_q & ~r_rco;

  always_comb begin
    w_state   = r_state;
    w_ret     = r_ret;
    w_wcnt    = r_wcnt;
    w_io_out  = r_io_out;
    w_rdata   = r_rdata;
    w_tick_ok = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_LD_DRV;
          w_io_out = r_preset;
        end else if (rd) begin
          w_state = S_RD_EN;
          w_ret   = S_IDLE;
          w_wcnt  = 16'd1;
        end
      end
      S_LD_DRV: w_state = S_LD_RCK;
      S_LD_RCK: w_state = S_LD_CLD;
      S_LD_CLD: w_state = S_RUN;
      S_RUN: begin
        if (w_fall) begin
`ifdef CTR593_RELOAD_EN
          w_state  = S_LD_DRV;
          w_io_out = r_preset;
`else
          w_state  = S_IDLE;
`endif
        end else if (stop) begin
          w_state = S_IDLE;
        end else if (rd) begin
          // an accepted read does not swallow a coincident tick
          w_state   = S_RD_EN;
          w_ret     = S_RUN;
          w_wcnt    = 16'd1;
          w_tick_ok = 1'b1;
        end else begin
          w_tick_ok = 1'b1;
        end
      end
      S_RD_EN: begin
        w_tick_ok = (r_ret == S_RUN);
        if (r_wcnt == c_wait) begin
          w_rdata = io_in;
          w_state = S_RD_TURN;
        end else begin
          w_wcnt = r_wcnt + 16'd1;
        end
      end
      S_RD_TURN: begin
        w_tick_ok = (r_ret == S_RUN);
        w_state   = r_ret;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // counting stays enabled through a readback that started in RUN
  assign w_rd_st    = (w_state == S_RD_EN) || (w_state == S_RD_TURN);
  assign w_counting = (w_state == S_RUN) || (w_rd_st && (w_ret == S_RUN));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_ret     <= S_IDLE;
      r_wcnt    <= 16'd0;
      r_preset  <= 8'd0;
      r_io_out  <= 8'd0;
      r_rdata   <= 8'd0;
      r_rco     <= 1'b1;
      r_rco_q   <= 1'b1;
      r_oe      <= 1'b0;
      r_cck     <= 1'b0;
      r_rck     <= 1'b0;
      r_ccken   <= 1'b1;
      r_cclr    <= 1'b0;
      r_cload   <= 1'b1;
      r_g       <= 1'b0;
      r_gn      <= 1'b1;
      r_rvalid  <= 1'b0;
      r_tc      <= 1'b0;
      r_busy    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ret     <= w_ret;
      r_wcnt    <= w_wcnt;
      r_io_out  <= w_io_out;
      r_rdata   <= w_rdata;
      r_rco     <= rco;
      r_rco_q   <= r_rco;
      if (wr) r_preset <= wdata;
      r_oe      <= (w_state == S_LD_DRV) || (w_state == S_LD_RCK);
      r_cck     <= w_tick_ok & tick & ~r_cck;
      r_rck     <= (w_state == S_LD_RCK);
      r_ccken   <= ~w_counting;
      r_cclr    <= 1'b1;
      r_cload   <= (w_state != S_LD_CLD);
      r_g       <= (w_state == S_RD_EN);
      r_gn      <= (w_state != S_RD_EN);
      r_rvalid  <= (w_state == S_RD_TURN);
      r_tc      <= w_fall;
      r_busy    <= (w_state == S_LD_DRV) || (w_state == S_LD_RCK) ||
                   (w_state == S_LD_CLD) || w_rd_st;
      r_running <= w_counting;
    end
  end

  assign io_out  = r_io_out;
  assign io_oe   = r_oe;
  assign cck     = r_cck;
  assign rck     = r_rck;
  assign ccken   = r_ccken;
  assign cclr    = r_cclr;
  assign cload   = r_cload;
  assign g       = r_g;
  assign g_      = r_gn;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign tc      = r_tc;
  assign busy    = r_busy;
  assign running = r_running;

endmodule

`default_nettype wire

// File: tb/tb_ctr593_seq.sv
// ============================================================================
// tb_ctr593_seq : directed stimulus with a cycle-stamped expectation scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ctr593_seq;

  localparam int SIG_CCK = 0, SIG_RCK = 1, SIG_CCKEN = 2, SIG_CCLR = 3, SIG_CLOAD = 4;
  localparam int SIG_G = 5, SIG_GN = 6, SIG_OE = 7, SIG_IOOUT = 8, SIG_RVALID = 9;
  localparam int SIG_TC = 10, SIG_BUSY = 11, SIG_RUNNING = 12, SIG_RDATA = 13;

  logic       clk = 1'b0;
  logic       clr, wr, start, stop, rd, tick;
  logic [7:0] wdata;
  logic       rco;
  logic [7:0] io_in, io_out, rdata;
  logic       io_oe, cck, rck, ccken, cclr, cload, g, g_n, rvalid, tc, busy, running;

  ctr593_seq #(.RD_WAIT(3)) dut (
    .clk(clk), .clr(clr), .wr(wr), .wdata(wdata), .start(start), .stop(stop),
    .rd(rd), .tick(tick), .rco(rco), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .cck(cck), .rck(rck), .ccken(ccken), .cclr(cclr), .cload(cload), .g(g), .g_(g_n),
    .rdata(rdata), .rvalid(rvalid), .tc(tc), .busy(busy), .running(running)
  );

  always #5 clk = ~clk;

  // LS593 behavioural model: input register on rck rise, load on cload low, count on cck rise
  logic [7:0] dev_reg = 8'h00;
  logic [7:0] dev_cnt = 8'h00;
  logic       rck_q = 1'b0, cck_q = 1'b0;
  always @(posedge clk) begin
    rck_q <= rck;
    cck_q <= cck;
    if (rck && !rck_q && io_oe) dev_reg <= io_out;
    if (!cclr)                          dev_cnt <= 8'h00;
    else if (!cload)                    dev_cnt <= dev_reg;
    else if (cck && !cck_q && !ccken)   dev_cnt <= dev_cnt + 8'h01;
  end
  assign rco   = (dev_cnt != 8'hFF);
  assign io_in = g ? dev_cnt : 8'h00;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sig; logic [7:0] val; } exp_t;
  exp_t       eq[$];
  exp_t       keep[$];
  logic [7:0] rd_q[$];
  logic [7:0] act, rexp;
  int         errors = 0;
  int         checks = 0;

  function automatic string sname(input int s);
    case (s)
      SIG_CCK: return "cck";       SIG_RCK: return "rck";     SIG_CCKEN: return "ccken";
      SIG_CCLR: return "cclr";     SIG_CLOAD: return "cload"; SIG_G: return "g";
      SIG_GN: return "g_";         SIG_OE: return "io_oe";    SIG_IOOUT: return "io_out";
      SIG_RVALID: return "rvalid"; SIG_TC: return "tc";       SIG_BUSY: return "busy";
      SIG_RUNNING: return "running";
      default: return "rdata";
    endcase
  endfunction

  function automatic logic [7:0] sample(input int s);
    case (s)
      SIG_CCK: return {7'd0, cck};       SIG_RCK: return {7'd0, rck};
      SIG_CCKEN: return {7'd0, ccken};   SIG_CCLR: return {7'd0, cclr};
      SIG_CLOAD: return {7'd0, cload};   SIG_G: return {7'd0, g};
      SIG_GN: return {7'd0, g_n};        SIG_OE: return {7'd0, io_oe};
      SIG_IOOUT: return io_out;          SIG_RVALID: return {7'd0, rvalid};
      SIG_TC: return {7'd0, tc};         SIG_BUSY: return {7'd0, busy};
      SIG_RUNNING: return {7'd0, running};
      default: return rdata;
    endcase
  endfunction

  task automatic expect_at(input int off, input int sig, input logic [7:0] v);
    exp_t e;
    e.cyc = cyc + off;
    e.sig = sig;
    e.val = v;
    eq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // monitor: compares due expectations and every rvalid against the readback queue
  always @(negedge clk) begin
    keep = {};
    foreach (eq[i]) begin
      if (eq[i].cyc <= cyc) begin
        checks = checks + 1;
        act = sample(eq[i].sig);
        if (eq[i].cyc < cyc || act !== eq[i].val) begin
          errors = errors + 1;
          $display("FAIL %s at cycle %0d: got %h, expected %h (due cycle %0d)",
                   sname(eq[i].sig), cyc, act, eq[i].val, eq[i].cyc);
        end
      end else begin
        keep.push_back(eq[i]);
      end
    end
    eq = keep;
    if (rvalid === 1'b1) begin
      checks = checks + 1;
      if (rd_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL rvalid at cycle %0d: got rdata %h, expected no readback", cyc, rdata);
      end else begin
        rexp = rd_q.pop_front();
        if (rdata !== rexp) begin
          errors = errors + 1;
          $display("FAIL rdata at cycle %0d: got %h, expected %h", cyc, rdata, rexp);
        end
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: bench did not complete within 3000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    clr = 1'b1; wr = 1'b0; wdata = 8'h00; start = 1'b0; stop = 1'b0; rd = 1'b0; tick = 1'b0;
    // reset values, visible in cycle 2
    expect_at(2, SIG_CCLR, 8'h0);  expect_at(2, SIG_CCK, 8'h0);    expect_at(2, SIG_RCK, 8'h0);
    expect_at(2, SIG_CCKEN, 8'h1); expect_at(2, SIG_CLOAD, 8'h1);  expect_at(2, SIG_G, 8'h0);
    expect_at(2, SIG_GN, 8'h1);    expect_at(2, SIG_OE, 8'h0);     expect_at(2, SIG_IOOUT, 8'h00);
    expect_at(2, SIG_RVALID, 8'h0); expect_at(2, SIG_TC, 8'h0);    expect_at(2, SIG_BUSY, 8'h0);
    expect_at(2, SIG_RUNNING, 8'h0); expect_at(2, SIG_RDATA, 8'h00);
    idle(2);

    // preset F0 and load sequence
    clr = 1'b0; wr = 1'b1; wdata = 8'hF0;
    step();
    wr = 1'b0; start = 1'b1;
    expect_at(1, SIG_OE, 8'h1);    expect_at(1, SIG_IOOUT, 8'hF0); expect_at(1, SIG_BUSY, 8'h1);
    expect_at(1, SIG_RCK, 8'h0);   expect_at(1, SIG_CCLR, 8'h1);
    expect_at(2, SIG_OE, 8'h1);    expect_at(2, SIG_IOOUT, 8'hF0); expect_at(2, SIG_RCK, 8'h1);
    expect_at(3, SIG_RCK, 8'h0);   expect_at(3, SIG_CLOAD, 8'h0);  expect_at(3, SIG_OE, 8'h0);
    expect_at(4, SIG_CLOAD, 8'h1); expect_at(4, SIG_CCKEN, 8'h0);  expect_at(4, SIG_RUNNING, 8'h1);
    expect_at(4, SIG_BUSY, 8'h0);
    step(); start = 1'b0;
    idle(3);
    stop = 1'b1;
    expect_at(1, SIG_CCKEN, 8'h1); expect_at(1, SIG_RUNNING, 8'h0);
    step(); stop = 1'b0;

    // readback of 5A from RUN
    wr = 1'b1; wdata = 8'h5A;
    step(); wr = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    idle(3);
    rd = 1'b1;
    rd_q.push_back(8'h5A);
    expect_at(1, SIG_G, 8'h1);  expect_at(1, SIG_GN, 8'h0);  expect_at(1, SIG_OE, 8'h0);
    expect_at(2, SIG_G, 8'h1);  expect_at(2, SIG_OE, 8'h0);
    expect_at(3, SIG_G, 8'h1);  expect_at(3, SIG_OE, 8'h0);
    expect_at(4, SIG_G, 8'h0);  expect_at(4, SIG_GN, 8'h1);  expect_at(4, SIG_RVALID, 8'h1);
    expect_at(4, SIG_OE, 8'h0); expect_at(5, SIG_RVALID, 8'h0);
    expect_at(5, SIG_RUNNING, 8'h1); expect_at(5, SIG_BUSY, 8'h0);
    step(); rd = 1'b0;
    idle(4);

    // four back-to-back ticks give two cck pulses (5A -> 5C)
    tick = 1'b1;
    expect_at(1, SIG_CCK, 8'h1); expect_at(2, SIG_CCK, 8'h0); expect_at(3, SIG_CCK, 8'h1);
    expect_at(4, SIG_CCK, 8'h0); expect_at(5, SIG_CCK, 8'h0);
    idle(4); tick = 1'b0;
    idle(1);

    // tick together with rd: one count (5C -> 5D) and a read
    tick = 1'b1; rd = 1'b1;
    rd_q.push_back(8'h5D);
    expect_at(1, SIG_CCK, 8'h1); expect_at(1, SIG_G, 8'h1); expect_at(2, SIG_CCK, 8'h0);
    expect_at(4, SIG_RVALID, 8'h1);
    step(); tick = 1'b0; rd = 1'b0;
    idle(4);

    // stop together with rd: stop wins, no enable
    stop = 1'b1; rd = 1'b1;
    expect_at(1, SIG_CCKEN, 8'h1); expect_at(1, SIG_G, 8'h0); expect_at(1, SIG_RUNNING, 8'h0);
    expect_at(1, SIG_BUSY, 8'h0);  expect_at(2, SIG_G, 8'h0); expect_at(2, SIG_RVALID, 8'h0);
    step(); stop = 1'b0; rd = 1'b0;
    idle(1);

    // count from FC to terminal with ticks every 2 cycles; rco low after the third
    wr = 1'b1; wdata = 8'hFC;
    step(); wr = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    idle(3);
    expect_at(7, SIG_TC, 8'h0); expect_at(7, SIG_RUNNING, 8'h1);
    expect_at(8, SIG_TC, 8'h1); expect_at(9, SIG_TC, 8'h0);
    expect_at(8, SIG_RUNNING, 8'h0); expect_at(8, SIG_CCKEN, 8'h1);
`ifdef CTR593_RELOAD_EN
    expect_at(8, SIG_OE, 8'h1);    expect_at(8, SIG_IOOUT, 8'hFC); expect_at(8, SIG_BUSY, 8'h1);
    expect_at(9, SIG_RCK, 8'h1);   expect_at(10, SIG_CLOAD, 8'h0);
    expect_at(11, SIG_RUNNING, 8'h1); expect_at(11, SIG_CCKEN, 8'h0);
`else
    expect_at(8, SIG_BUSY, 8'h0);  expect_at(9, SIG_RUNNING, 8'h0);
    expect_at(10, SIG_OE, 8'h0);   expect_at(10, SIG_CCKEN, 8'h1);
`endif
    for (int k = 0; k < 4; k++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    idle(4);
    stop = 1'b1;
    step(); stop = 1'b0;
    idle(1);

    // clr during LD_RCK aborts the sequence
    start = 1'b1;
    expect_at(2, SIG_RCK, 8'h1);
    step(); start = 1'b0;
    step();
    clr = 1'b1;
    expect_at(1, SIG_RCK, 8'h0);  expect_at(1, SIG_OE, 8'h0);   expect_at(1, SIG_CLOAD, 8'h1);
    expect_at(1, SIG_CCLR, 8'h0); expect_at(1, SIG_BUSY, 8'h0); expect_at(1, SIG_RUNNING, 8'h0);
    step(); clr = 1'b0;
    idle(3);

    foreach (eq[i]) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s never checked: expected %h at cycle %0d", sname(eq[i].sig), eq[i].val, eq[i].cyc);
    end
    foreach (rd_q[i]) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL rvalid missing: got no readback, expected rdata %h", rd_q[i]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
